seg_scan_ctrl: RTL and testbench

Scan controller for the 4-digit seven-segment score display.
- Accepts a binary score and converts it to BCD sequentially (shift-add-3, one bit per clock).
- Time-multiplexes the four digits onto a shared 4-bit digit bus and drives the active-low anodes.
- The digit bus feeds the team's existing digit-to-segment decoder, which treats 4'hF as all segments off.

---
 rtl/seg_scan_ctrl_if.sv | 32 +++
 rtl/seg_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl_if
// Bundles the score-load handshake and the display-scan outputs of
// seg_scan_ctrl.
//   value    : binary score, sampled on an accepted load
//   load     : request to convert and display value
//   blank_lz : 1 = blank leading zeros (live)
//   busy     : conversion in progress, load ignored while high
//   digit    : BCD digit of the active slot, 4'hF = blank
//   an       : active-low anode enables, an[0] = ones digit
// master = score source / display consumer, slave = seg_scan_ctrl.
// -----------------------------------------------------------------------------
interface seg_scan_ctrl_if #(
  parameter int BIN_W = 14
) ();
  logic [BIN_W-1:0] value;
  logic             load;
  logic             blank_lz;
  logic             busy;
  logic [3:0]       digit;
  logic [3:0]       an;

  modport master (
    output value, load, blank_lz,
    input  busy, digit, an
  );

  modport slave (
    input  value, load, blank_lz,
    output busy, digit, an
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
// Scan controller for the 4-digit seven-segment score display.
//  - Converts a clamped binary score to BCD with shift-add-3, one bit per
//    clock, and swaps all four nibbles into the shown register at once.
//  - Time-multiplexes the shown digits onto a 4-bit digit bus, one slot per
//    REFRESH_DIV clocks, with matching active-low anodes.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous reset, active-low
//   bus   : seg_scan_ctrl_if.slave (value/load/blank_lz in, busy/digit/an out)
// Parameters:
//   REFRESH_DIV : clocks per digit slot (2 .. 2**20)
//   BIN_W       : width of the binary score
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int BIN_W       = 14
) (
  input  logic            clk,
  input  logic            rst_n,
  seg_scan_ctrl_if.slave  bus
);

  localparam int RW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int CW      = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  // Largest value the input can carry that is still displayable.
  localparam int MAX_INT = (BIN_W >= 14) ? 9999 : ((2 ** BIN_W) - 1);

  localparam logic [BIN_W-1:0] MAX_VAL  = BIN_W'(MAX_INT);
  localparam logic [RW-1:0]    REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(BIN_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q,   state_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [BIN_W-1:0] shift_q,   shift_d;
  logic [15:0]      bcd_q,     bcd_d;
  logic [15:0]      shown_q,   shown_d;
  logic [RW-1:0]    refresh_q, refresh_d;
  logic [1:0]       slot_q,    slot_d;
  logic [3:0]       an_q,      an_d;
  logic [3:0]       digit_q,   digit_d;

  logic [15:0]      bcd_adj;
  logic [15:0]      bcd_next;
  logic [3:0]       zero_from;  // zero_from[i]: nibble i and all above are 0

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    shown_d   = shown_q;
    refresh_d = refresh_q;
    slot_d    = slot_q;
    bcd_adj   = bcd_q;
    bcd_next  = '0;
    zero_from = '0;
    an_d      = 4'b1110;
    digit_d   = 4'h0;

    // One double-dabble step: correct nibbles >= 5, then shift in the MSB.
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_next = {bcd_adj[14:0], shift_q[BIN_W-1]};

    unique case (state_q)
      IDLE: begin
        if (bus.load) begin
          shift_d = (bus.value > MAX_VAL) ? MAX_VAL : bus.value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d   = bcd_next;
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // Display swaps to the finished result in a single edge.
          shown_d = bcd_next;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Free-running scan, independent of conversion activity.
    if (refresh_q == REF_LAST) begin
      refresh_d = '0;
      slot_d    = slot_q + 2'd1;
    end else begin
      refresh_d = refresh_q + RW'(1);
    end

    // digit/an are computed from next-state values so both registers change
    // on the same edge as the slot and the shown register.
    zero_from[3] = (shown_d[15:12] == 4'h0);
    zero_from[2] = zero_from[3] && (shown_d[11:8] == 4'h0);
    zero_from[1] = zero_from[2] && (shown_d[7:4]  == 4'h0);
    zero_from[0] = 1'b0;  // ones digit is always shown

    an_d    = ~(4'b0001 << slot_d);
    digit_d = shown_d[4*slot_d +: 4];
    if (bus.blank_lz && zero_from[slot_d]) begin
      digit_d = 4'hF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the shown register is reset along with the control state so
      // the display reads 0 (not leftover data) after reset, including an
      // aborted conversion.
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      bcd_q     <= '0;
      shown_q   <= '0;
      refresh_q <= '0;
      slot_q    <= 2'd0;
      an_q      <= 4'b1110;
      digit_q   <= 4'h0;
    end else begin
      // NOTE: non-blocking assignments only, so every register samples the
      // pre-edge values regardless of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      shown_q   <= shown_d;
      refresh_q <= refresh_d;
      slot_q    <= slot_d;
      an_q      <= an_d;
      digit_q   <= digit_d;
    end
  end

  assign bus.busy  = (state_q == SHIFT);
  assign bus.an    = an_q;
  assign bus.digit = digit_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Self-checking bench for seg_scan_ctrl. A decimal-arithmetic reference model
// tracks the displayed score, remaining conversion time and scan position;
// busy/an/digit are compared every cycle, plus directed scan-round checks
// against constant digit patterns.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int RDIV = 4;
  localparam int BW   = 14;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.BIN_W(BW)) bus ();

  seg_scan_ctrl #(
    .REFRESH_DIV (RDIV),
    .BIN_W       (BW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int         m_t;        // edges since the last reset edge
  int         m_remain;   // conversion cycles still to run
  int         m_pending;  // score being converted
  int         m_shown;    // score currently displayed
  int         m_slot;
  logic       m_busy;
  logic [3:0] m_an;
  logic [3:0] m_digit;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_digit(input int v, input int s,
                                           input logic blz);
    int p;
    p = 10 ** s;
    if (blz && s > 0 && v < p) return 4'hF;
    return 4'((v / p) % 10);
  endfunction

  // Model update for one rising edge, using the inputs held across it.
  task automatic model_edge();
    if (!rst_n) begin
      m_t      = 0;
      m_remain = 0;
      m_shown  = 0;
      m_slot   = 0;
      m_digit  = 4'h0;
    end else begin
      m_t++;
      if (m_remain > 0) begin
        m_remain--;
        if (m_remain == 0) m_shown = m_pending;
      end else if (bus.load) begin
        m_pending = (int'(bus.value) > 9999) ? 9999 : int'(bus.value);
        m_remain  = BW;
      end
      m_slot  = (m_t / RDIV) % 4;
      m_digit = ref_digit(m_shown, m_slot, bus.blank_lz);
    end
    m_an   = ~(4'b0001 << m_slot);
    m_busy = (m_remain > 0);
  endtask

  // One clock: edge, model, compare at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("busy",  {31'd0, bus.busy}, {31'd0, m_busy});
    check("an",    {28'd0, bus.an},    {28'd0, m_an});
    check("digit", {28'd0, bus.digit}, {28'd0, m_digit});
  endtask

  task automatic do_load(input int v);
    bus.value = BW'(v);
    bus.load  = 1'b1;
    cycle();
    bus.load  = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (bus.busy && g < BW + 4) begin
      cycle();
      g++;
    end
    if (bus.busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Walk one scan round and compare each slot against constant digits.
  task automatic round_check(input string tag, input logic [3:0] d0,
                             input logic [3:0] d1, input logic [3:0] d2,
                             input logic [3:0] d3);
    logic [3:0] exp_d [4];
    int g;
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
    for (int k = 0; k < 4; k++) begin
      g = 0;
      while (m_slot != k && g < 4 * RDIV + 2) begin
        cycle();
        g++;
      end
      if (m_slot != k) check("slot_timeout", 32'd1, 32'd0);
      check(tag, {28'd0, bus.digit}, {28'd0, exp_d[k]});
      check({tag, "_an"}, {28'd0, bus.an}, {28'd0, ~(4'b0001 << k)});
    end
  endtask

  initial begin
    int n;

    // Reset held 3 cycles with blanking enabled.
    rst_n        = 1'b0;
    bus.load     = 1'b0;
    bus.value    = '0;
    bus.blank_lz = 1'b1;
    m_pending    = 0;
    repeat (3) cycle();
    check("rst_busy",  {31'd0, bus.busy},  32'd0);
    check("rst_an",    {28'd0, bus.an},    32'b1110);
    check("rst_digit", {28'd0, bus.digit}, 32'd0);
    rst_n = 1'b1;
    round_check("rst_blank", 4'h0, 4'hF, 4'hF, 4'hF);

    // Latency and basic conversion.
    do_load(1234);
    n = 0;
    while (bus.busy && n < 40) begin
      cycle();
      n++;
    end
    check("busy_len", n, 14);
    round_check("v1234", 4'd4, 4'd3, 4'd2, 4'd1);

    // Leading-zero blanking.
    do_load(7);
    wait_idle();
    round_check("v7_blz", 4'd7, 4'hF, 4'hF, 4'hF);
    bus.blank_lz = 1'b0;
    cycle();
    round_check("v7_noblz", 4'd7, 4'd0, 4'd0, 4'd0);
    bus.blank_lz = 1'b1;
    do_load(1005);
    wait_idle();
    round_check("v1005", 4'd5, 4'd0, 4'd0, 4'd1);

    // Clamp and extremes.
    do_load(16383);
    wait_idle();
    round_check("v16383", 4'd9, 4'd9, 4'd9, 4'd9);
    do_load(9999);
    wait_idle();
    round_check("v9999", 4'd9, 4'd9, 4'd9, 4'd9);
    do_load(0);
    wait_idle();
    round_check("v0", 4'd0, 4'hF, 4'hF, 4'hF);

    // Load during busy is ignored.
    do_load(42);
    repeat (4) cycle();
    do_load(99);
    wait_idle();
    round_check("collide", 4'd2, 4'd4, 4'hF, 4'hF);

    // Held load re-triggers once busy drops.
    bus.value = BW'(99);
    bus.load  = 1'b1;
    repeat (2 * (BW + 1) + 2) cycle();
    bus.load  = 1'b0;
    wait_idle();
    round_check("held", 4'd9, 4'd9, 4'hF, 4'hF);

    // Reset on cycle 7 of a conversion.
    do_load(5678);
    repeat (6) cycle();
    rst_n = 1'b0;
    cycle();
    check("mid_rst_busy",  {31'd0, bus.busy},  32'd0);
    check("mid_rst_an",    {28'd0, bus.an},    32'b1110);
    check("mid_rst_digit", {28'd0, bus.digit}, 32'd0);
    rst_n = 1'b1;
    round_check("mid_rst", 4'd0, 4'hF, 4'hF, 4'hF);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bus.load = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) bus.value = BW'($urandom_range(9990, 16383));
      else bus.value = BW'($urandom_range(0, 10 ** $urandom_range(1, 4) - 1));
      if ($urandom_range(0, 30) == 0) bus.blank_lz = ~bus.blank_lz;
      rst_n = ($urandom_range(0, 250) != 0);
      cycle();
    end
    rst_n    = 1'b1;
    bus.load = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
